// File: rtl/q_ifid_pkg.sv
// Shared types and defaults for the IF/ID instruction-pair queue.
package q_ifid_pkg;

    localparam int unsigned IFID_DEPTH = 8;
    localparam int unsigned IFID_AW    = 3;

    // One queue entry: the fetched instruction pair and its two addresses.
    typedef struct packed {
        logic [31:0] Instr1;
        logic [31:0] Instr2;
        logic [31:0] PCA;
        logic [31:0] CIA;
    } ifid_entry_t;

endpackage

// File: rtl/q_ifid_ram.sv
// Entry storage for q_ifid: synchronous write, asynchronous read, no reset.
module q_ifid_ram
    import q_ifid_pkg::*;
#(
    parameter int unsigned DEPTH = IFID_DEPTH,
    parameter int unsigned AW    = IFID_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ifid_entry_t   wdata,
    input  logic [AW-1:0] raddr,
    output ifid_entry_t   rdata
);

    ifid_entry_t mem [DEPTH];

    // Write the offered entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/q_ifid.sv
// IF/ID queue: FIFO of instruction pairs between fetch and decode, with flush
// and sticky overflow/underflow flags. Head is read combinationally.
module q_ifid
    import q_ifid_pkg::*;
#(
    parameter int unsigned DEPTH = IFID_DEPTH,
    parameter int unsigned AW    = IFID_AW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          pushReq,
    input  logic [31:0]   Instr1_in,
    input  logic [31:0]   Instr2_in,
    input  logic [31:0]   PCA_in,
    input  logic [31:0]   CIA_in,
    input  logic          popReq,
    input  logic          flush,
    output logic [31:0]   Instr1_out,
    output logic [31:0]   Instr2_out,
    output logic [31:0]   PCA_out,
    output logic [31:0]   CIA_out,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf_err,
    output logic          udf_err
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push_ok, pop_ok;
    ifid_entry_t   wr_entry, rd_entry, head;

    // Flags come from the registered count only, never from the requests.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Flush overrides both sides; a full/empty queue rejects regardless of the other side.
    assign push_ok = pushReq & ~full & ~flush;
    assign pop_ok  = popReq & ~empty & ~flush;

    assign wr_entry = '{Instr1: Instr1_in, Instr2: Instr2_in, PCA: PCA_in, CIA: CIA_in};

    q_ifid_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Next-state for pointers, count and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (pushReq && full) begin
                ovf_d = 1'b1;
            end
            if (popReq && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    // State registers; reset empties the queue immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Head reads zero when empty so stale storage never leaks out.
    always_comb begin
        head = empty ? '0 : rd_entry;
    end

    assign Instr1_out = head.Instr1;
    assign Instr2_out = head.Instr2;
    assign PCA_out    = head.PCA;
    assign CIA_out    = head.CIA;
    assign count      = count_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

endmodule

// File: tb/tb_q_ifid.sv
// Directed self-checking bench for q_ifid.
module tb_q_ifid;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        pushReq, popReq, flush;
    logic [31:0] Instr1_in, Instr2_in, PCA_in, CIA_in;
    logic [31:0] Instr1_out, Instr2_out, PCA_out, CIA_out;
    logic        full, empty, ovf_err, udf_err;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    q_ifid dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .pushReq    (pushReq),
        .Instr1_in  (Instr1_in),
        .Instr2_in  (Instr2_in),
        .PCA_in     (PCA_in),
        .CIA_in     (CIA_in),
        .popReq     (popReq),
        .flush      (flush),
        .Instr1_out (Instr1_out),
        .Instr2_out (Instr2_out),
        .PCA_out    (PCA_out),
        .CIA_out    (CIA_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry i: Instr1=i, Instr2=i+100, PCA=4*i, CIA=4*i+4.
    task automatic set_entry(input int i);
        Instr1_in = 32'(i);
        Instr2_in = 32'(i + 100);
        PCA_in    = 32'(4 * i);
        CIA_in    = 32'(4 * i + 4);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; pushReq = 1'b0; popReq = 1'b0; flush = 1'b0;
        set_entry(0);
        #2 RESET = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_udf", 32'(udf_err), 32'd0);
        check("rst_head", Instr1_out, 32'd0);
        @(negedge CLK) RESET = 1'b1;

        // Fill to full, then one rejected push.
        for (int i = 0; i < 8; i++) begin
            set_entry(i); pushReq = 1'b1;
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        set_entry(99);
        tick();
        pushReq = 1'b0;
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_udf", 32'(udf_err), 32'd0);
        check("ovf_head", Instr1_out, 32'd0);

        // Drain in order, then one rejected pop.
        for (int i = 0; i < 8; i++) begin
            check("drain_i1", Instr1_out, 32'(i));
            check("drain_i2", Instr2_out, 32'(i + 100));
            check("drain_pca", PCA_out, 32'(4 * i));
            check("drain_cia", CIA_out, 32'(4 * i + 4));
            popReq = 1'b1;
            tick();
        end
        popReq = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full", 32'(full), 32'd0);
        check("drain_i1z", Instr1_out, 32'd0);
        check("drain_i2z", Instr2_out, 32'd0);
        check("drain_pcaz", PCA_out, 32'd0);
        check("drain_ciaz", CIA_out, 32'd0);
        popReq = 1'b1;
        tick();
        popReq = 1'b0;
        check("udf_set", 32'(udf_err), 32'd1);
        check("udf_count", 32'(count), 32'd0);

        // Reset clears the sticky flags.
        @(negedge CLK) RESET = 1'b0;
        #1;
        check("rst2_ovf", 32'(ovf_err), 32'd0);
        check("rst2_udf", 32'(udf_err), 32'd0);
        @(negedge CLK) RESET = 1'b1;

        // Steady push+pop at count 3 across pointer wrap.
        pushReq = 1'b1;
        for (int i = 200; i < 203; i++) begin
            set_entry(i);
            tick();
        end
        check("ss_count0", 32'(count), 32'd3);
        popReq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_entry(203 + k);
            check("ss_head", Instr1_out, 32'(200 + k));
            check("ss_pca", PCA_out, 32'(4 * (200 + k)));
            tick();
            check("ss_count", 32'(count), 32'd3);
        end
        pushReq = 1'b0; popReq = 1'b0;
        check("ss_head_end", Instr1_out, 32'd220);
        check("ss_ovf", 32'(ovf_err), 32'd0);
        check("ss_udf", 32'(udf_err), 32'd0);

        // Flush with a push at count 5.
        pushReq = 1'b1;
        set_entry(300); tick();
        set_entry(301); tick();
        check("pre_flush_count", 32'(count), 32'd5);
        set_entry(400); flush = 1'b1;
        tick();
        pushReq = 1'b0; flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_head", Instr1_out, 32'd0);
        check("flush_ovf", 32'(ovf_err), 32'd0);
        check("flush_udf", 32'(udf_err), 32'd0);
        set_entry(500); pushReq = 1'b1;
        tick();
        pushReq = 1'b0;
        check("post_flush_head", Instr1_out, 32'd500);
        check("post_flush_count", 32'(count), 32'd1);
        flush = 1'b1;
        tick();
        check("flush2_empty", 32'(empty), 32'd1);
        popReq = 1'b1;
        tick();
        flush = 1'b0; popReq = 1'b0;
        check("flush_pop_udf", 32'(udf_err), 32'd0);

        // Push into empty with a pop request: pop rejected.
        set_entry(600); pushReq = 1'b1; popReq = 1'b1;
        check("pe_head_before", Instr1_out, 32'd0);
        tick();
        pushReq = 1'b0; popReq = 1'b0;
        check("pe_udf", 32'(udf_err), 32'd1);
        check("pe_count", 32'(count), 32'd1);
        check("pe_head", Instr1_out, 32'd600);
        check("pe_head2", Instr2_out, 32'd700);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_keeps_udf", 32'(udf_err), 32'd1);
        check("flush3_count", 32'(count), 32'd0);

        // Asynchronous reset mid-operation at count 4.
        pushReq = 1'b1;
        for (int i = 700; i < 704; i++) begin
            set_entry(i);
            tick();
        end
        pushReq = 1'b0;
        check("ar_count_pre", 32'(count), 32'd4);
        @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_head", Instr1_out, 32'd0);
        check("ar_udf", 32'(udf_err), 32'd0);
        @(negedge CLK) RESET = 1'b1;
        set_entry(800); pushReq = 1'b1;
        check("ar_head_before", Instr1_out, 32'd0);
        tick();
        pushReq = 1'b0;
        check("ar_first_head", Instr1_out, 32'd800);
        check("ar_first_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
